// File: rtl/sad_lane_engine.sv
// Multi-lane SAD engine: fetches LANES pixel pairs per beat, runs |A-B| -> lane sum -> accumulate.
// Optional build macro SAD_SAT_EN: saturating accumulator with a sticky ovf flag (wraps when undefined).

module sad_lane_absdiff #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_sgn,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W:0]   o_ad
);
    logic [DATA_W:0]   w_ae, w_be, w_neg, w_abs;
    logic [DATA_W+1:0] w_diff;
    logic [DATA_W:0]   r_ad;

    assign w_ae   = {i_sgn & i_a[DATA_W-1], i_a};
    assign w_be   = {i_sgn & i_b[DATA_W-1], i_b};
    // one extra bit keeps the borrow so the sign of the difference is exact
    assign w_diff = {w_ae[DATA_W], w_ae} - {w_be[DATA_W], w_be};
    assign w_neg  = ~w_diff[DATA_W:0] + {{DATA_W{1'b0}}, 1'b1};
    assign w_abs  = w_diff[DATA_W+1] ? w_neg : w_diff[DATA_W:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_ad <= '0;
        else if (i_en) r_ad <= w_abs;
    end

    assign o_ad = r_ad;
endmodule

module sad_lane_engine #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 256,
    parameter int SAD_W  = 32,
    parameter int ADDR_W = (DEPTH / LANES > 1) ? $clog2(DEPTH / LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic                    sgn,
    input  logic [LANES*DATA_W-1:0] A_data,
    input  logic [LANES*DATA_W-1:0] B_data,
    output logic [ADDR_W-1:0]       AB_addr,
    output logic                    AB_rd,
    output logic                    busy,
    output logic                    done,
    output logic [SAD_W-1:0]        sad,
    output logic                    ovf
);
    localparam int W     = DEPTH / LANES;
    localparam int SUM_W = DATA_W + 1 + $clog2(LANES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic [ADDR_W-1:0]         r_addr;
    logic [1:0]                r_dcnt;
    logic                      r_sgn;
    logic [1:0]                r_vld_pipe;
    logic [LANES-1:0][DATA_W:0] w_ad;
    logic [SUM_W-1:0]          w_tree, r_s2;
    logic [SAD_W-1:0]          r_acc, r_sad, w_acc_nx;
    logic                      w_start, w_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (go) w_next = S_RUN;
            S_RUN:   if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: if (r_dcnt == 2'd2) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_start  = (r_state == S_IDLE) && go;
    assign w_finish = (r_state == S_DRAIN) && (w_next == S_DONE);

    assign AB_addr = r_addr;
    assign AB_rd   = (r_state == S_RUN);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign sad     = r_sad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_dcnt <= '0;
            r_sgn  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (go) begin
                    r_addr <= '0;
                    r_sgn  <= sgn;
                end
                S_RUN: begin
                    if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
                    r_dcnt <= '0;
                end
                S_DRAIN: r_dcnt <= r_dcnt + 1'b1;
                default: ;
            endcase
        end
    end

    // S1: one |A-B| register per lane, loaded on every read beat
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sad_lane_absdiff #(.DATA_W(DATA_W)) u_ad (
            .clk   (clk),
            .rst   (rst),
            .i_en  (AB_rd),
            .i_sgn (r_sgn),
            .i_a   (A_data[l*DATA_W +: DATA_W]),
            .i_b   (B_data[l*DATA_W +: DATA_W]),
            .o_ad  (w_ad[l])
        );
    end

    always_comb begin
        w_tree = '0;
        for (int l = 0; l < LANES; l++) w_tree = w_tree + SUM_W'(w_ad[l]);
    end

`ifdef SAD_SAT_EN
    logic [SAD_W:0] w_sum;
    logic           r_ovf_acc, r_ovf;

    assign w_sum    = {1'b0, r_acc} + (SAD_W+1)'(r_s2);
    assign w_acc_nx = w_sum[SAD_W] ? {SAD_W{1'b1}} : w_sum[SAD_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_acc <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_start)                           r_ovf_acc <= 1'b0;
            else if (r_vld_pipe[1] && w_sum[SAD_W]) r_ovf_acc <= 1'b1;
            if (w_finish) r_ovf <= r_ovf_acc;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_acc_nx = r_acc + SAD_W'(r_s2);
    assign ovf      = 1'b0;
`endif

    // S2 lane sum and S3 accumulate; valid bits track beats through the flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_s2       <= '0;
            r_acc      <= '0;
            r_sad      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], AB_rd};
            if (r_vld_pipe[0]) r_s2 <= w_tree;
            if (w_start)            r_acc <= '0;
            else if (r_vld_pipe[1]) r_acc <= w_acc_nx;
            if (w_finish) r_sad <= r_acc;
        end
    end
endmodule

// File: tb/tb_sad_lane_engine.sv
// Directed bench for sad_lane_engine: vector table plus reset-abort and back-to-back sequences.
module tb_sad_lane_engine;
    logic        clk, rst, go, sgn;
    logic [31:0] a0, b0, a1, b1;
    logic [5:0]  addr0, addr1;
    logic        rd0, busy0, done0, ovf0, rd1, busy1, done1, ovf1;
    logic [31:0] sad0;
    logic [11:0] sad1;

    logic [7:0] memA [256];
    logic [7:0] memB [256];

    int n_cmp = 0;
    int n_bad = 0;
    int last_exp = 0;

    sad_lane_engine dut0 (
        .clk(clk), .rst(rst), .go(go), .sgn(sgn), .A_data(a0), .B_data(b0),
        .AB_addr(addr0), .AB_rd(rd0), .busy(busy0), .done(done0), .sad(sad0), .ovf(ovf0));

    sad_lane_engine #(.SAD_W(12)) dut1 (
        .clk(clk), .rst(rst), .go(go), .sgn(sgn), .A_data(a1), .B_data(b1),
        .AB_addr(addr1), .AB_rd(rd1), .busy(busy1), .done(done1), .sad(sad1), .ovf(ovf1));

    always #5 clk = ~clk;

    always_comb begin
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int i = 0; i < 4; i++) begin
            a0[i*8 +: 8] = memA[int'(addr0)*4 + i];
            b0[i*8 +: 8] = memB[int'(addr0)*4 + i];
            a1[i*8 +: 8] = memA[int'(addr1)*4 + i];
            b1[i*8 +: 8] = memB[int'(addr1)*4 + i];
        end
    end

    typedef struct {
        int         amode;   // 0 constant fill, 1 ramp A, 2 random A copied to B
        logic [7:0] av;
        logic [7:0] bv;
        logic       s;
        int         exp;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int amode, input logic [7:0] av, input logic [7:0] bv);
        for (int i = 0; i < 256; i++) begin
            case (amode)
                1:       begin memA[i] = 8'(i); memB[i] = bv; end
                2:       begin memA[i] = 8'($urandom_range(0, 255)); memB[i] = memA[i]; end
                default: begin memA[i] = av; memB[i] = bv; end
            endcase
        end
    endtask

    task automatic run(input logic s, input int exp, input string tag);
        int rd_cnt = 0;
        int done_cnt = 0;
        int done_edge = -1;
        int e12;
        logic o12;
`ifdef SAD_SAT_EN
        e12 = (exp > 4095) ? 4095 : exp;
        o12 = (exp > 4095);
`else
        e12 = exp % 4096;
        o12 = 1'b0;
`endif
        @(negedge clk); go = 1'b1; sgn = s;
        @(posedge clk); #1; go = 1'b0; sgn = ~s;
        for (int c = 1; c <= 72; c++) begin
            if (rd0) rd_cnt++;
            if (done0) begin
                done_cnt++;
                if (done_edge < 0) done_edge = c - 1;
            end
            if (c == 67) chk({tag, "_sad_held"}, sad0, last_exp);
            if (c == 10) go = 1'b1;
            if (c == 11) go = 1'b0;
            @(posedge clk); #1;
        end
        chk({tag, "_done_edge"}, done_edge, 67);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_rd_cnt"}, rd_cnt, 64);
        chk({tag, "_sad"}, sad0, exp);
        chk({tag, "_busy_end"}, busy0, 0);
        chk({tag, "_ovf"}, ovf0, 0);
        chk({tag, "_sad12"}, sad1, e12);
        chk({tag, "_ovf12"}, ovf1, o12);
        last_exp = exp;
    endtask

    initial begin
        int edges [3];
        int nd;
        clk = 1'b0; rst = 1'b1; go = 1'b0; sgn = 1'b0;
        fill(0, 8'h00, 8'h00);

        vt[0] = '{2, 8'h00, 8'h00, 1'b0, 0};
        vt[1] = '{0, 8'hFF, 8'h00, 1'b0, 65280};
        vt[2] = '{0, 8'h80, 8'h7F, 1'b0, 256};
        vt[3] = '{0, 8'h80, 8'h7F, 1'b1, 65280};
        vt[4] = '{0, 8'h00, 8'hFF, 1'b1, 256};
        vt[5] = '{0, 8'h7F, 8'h81, 1'b1, 65024};
        vt[6] = '{1, 8'h00, 8'h00, 1'b0, 32640};

        #23;
        chk("rst_addr", addr0, 0);
        chk("rst_rd", rd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_sad", sad0, 0);
        chk("rst_ovf", ovf0, 0);
        @(negedge clk); rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fill(vt[v].amode, vt[v].av, vt[v].bv);
            run(vt[v].s, vt[v].exp, $sformatf("vec%0d", v));
        end
        fill(1, 8'h00, 8'h00);
        run(1'b1, 16384, "ramp_sgn");

        // reset mid-run: outputs clear without waiting for a clock edge
        fill(0, 8'hFF, 8'h00);
        @(negedge clk); go = 1'b1; sgn = 1'b0;
        @(posedge clk); #1; go = 1'b0;
        repeat (20) @(posedge clk);
        #3; rst = 1'b1; #1;
        chk("abort_rd", rd0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_sad", sad0, 0);
        last_exp = 0;
        @(negedge clk); rst = 1'b0;
        nd = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done0) nd++;
        end
        chk("abort_no_done", nd, 0);
        run(1'b0, 65280, "after_abort");

        // go held high: three back-to-back runs
        fill(0, 8'h80, 8'h7F);
        nd = 0;
        @(negedge clk); go = 1'b1; sgn = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= 230; c++) begin
            if (done0) begin
                if (nd < 3) edges[nd] = c - 1;
                nd++;
                chk($sformatf("b2b_sad%0d", nd), sad0, 256);
                if (nd == 3) go = 1'b0;
            end
            @(posedge clk); #1;
        end
        go = 1'b0;
        chk("b2b_count", nd, 3);
        chk("b2b_first", edges[0], 67);
        chk("b2b_gap1", edges[1] - edges[0], 69);
        chk("b2b_gap2", edges[2] - edges[1], 69);
        chk("b2b_busy_end", busy0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sad_lane_engine.md
Name: sad_lane_engine

Overview:
- Parametrised successor to the single-pixel SAD block.
- Fetches LANES pixel pairs per read from the A/B pixel arrays, computes per-lane absolute differences through a 3-stage pipeline and accumulates the sum of absolute differences (SAD).
- Adds a signed/unsigned pixel mode, a busy/done handshake and a held result register.
- Sits between the frame-buffer read port and the motion-estimation controller.

Parameters:
- DATA_W, 8, pixel width in bits.
- LANES, 4, pixels per read beat; power of 2, at least 1.
- DEPTH, 256, pixels per block; multiple of LANES.
- SAD_W, 32, accumulator and result width.
- ADDR_W, $clog2(DEPTH/LANES), beat address width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- go  in  1  start request, sampled in IDLE only.
- sgn  in  1  1 = pixels are two's complement; sampled with go.
- A_data  in  LANES*DATA_W  lane i = bits [i*DATA_W +: DATA_W]; combinational read of AB_addr.
- B_data  in  LANES*DATA_W  same packing as A_data.
- AB_addr  out  ADDR_W  beat address.
- AB_rd  out  1  read strobe; high only in RUN.
- busy  out  1  high in RUN, DRAIN, DONE.
- done  out  1  one-cycle completion pulse.
- sad  out  SAD_W  last completed SAD; held until next completion.
- ovf  out  1  sticky overflow flag; constant 0 without SAD_SAT_EN.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE;
  - AB_addr, AB_rd, busy, done, sad, ovf = 0;
  - all pipeline registers and the accumulator = 0.
- Reset asserted mid-run aborts immediately; no done pulse is produced.
- W = DEPTH/LANES beats per block.
- States:
  - IDLE: go=1 at the edge moves to RUN. At that edge: latch sgn, clear acc, AB_addr=0.
  - RUN: AB_rd=1, AB_addr increments each cycle, addresses 0..W-1 issued once each. Leaves to DRAIN after address W-1.
  - DRAIN: exactly 3 cycles, flushing the pipeline; AB_rd=0, AB_addr holds W-1.
  - DONE: done=1 for one cycle; sad<=acc on entry; then returns to IDLE.
- Pipeline, per beat:
  - S1: per-lane |A-B| registered, width DATA_W+1. Operands are sign-extended when sgn latched = 1, zero-extended otherwise.
  - S2: adder tree result registered, width DATA_W+1+$clog2(LANES).
  - S3: acc += lane sum, modulo 2^SAD_W.
- Timing: go sampled at edge 0. Last address is presented in cycle W. done is high during the cycle after edge W+3.
- go held high gives back-to-back runs with a period of W+5 cycles, because IDLE occupies one cycle.
- go in RUN, DRAIN or DONE is ignored; it is not queued.
- sgn changes during a run have no effect.
- sad changes only on DONE entry.
- W=1 is legal: RUN lasts a single cycle.

Optional Feature:
- Macro: SAD_SAT_EN.
- Defined:
  - The S3 add saturates at 2^SAD_W-1.
  - On saturation, ovf is set; it is sticky until reset or the next go.
  - ovf updates with sad on DONE entry.
- Undefined:
  - The accumulator wraps.
  - ovf is tied 0.

Test Plan (DATA_W=8, LANES=4, DEPTH=256, W=64):
- memA=memB=random, sgn=0, go pulse -> sad=0; done high exactly one cycle, 67 edges after go sampled; AB_rd high 64 cycles.
- A=0xFF all, B=0x00 all, sgn=0 -> sad=65280; busy deasserts after DONE.
- A=0x80, B=0x7F all -> sgn=0: sad=256; rerun with sgn=1: sad=65280.
- Reset asserted at cycle 20 of RUN -> AB_rd, busy, done, sad all 0 asynchronously; a following go gives the correct result with no stray done.
- go held high for 3 runs, with go also pulsed during RUN -> exactly 3 done pulses spaced 69 cycles; each sad correct; mid-run go ignored.
- SAD_W=12, A=0xFF, B=0x00 -> with SAD_SAT_EN: sad=4095, ovf=1. Without SAD_SAT_EN: sad=3840, ovf=0.
